// File: rtl/aquaflex_route_seq.sv
// aquaflex_route_seq: timed flow-route sequencer (load -> mix -> drain).
// Each accepted request opens the selected inlet with pump A, runs the
// mixer, then opens the selected outlet with pump C, with one idle gap
// cycle between phases so that no two phases ever drive actuators back
// to back.
// Optional build macro: AQUAFLEX_FLUSH_EN adds GAP0 + FLUSH after DRAIN.
//
// Request handshake: a request transfers on a rising edge where
// req_valid && req_ready. req_ready is high in IDLE and in DONE (unless
// abort is asserted in that DONE cycle). The select fields and
// req_mix_cyc are captured on that edge; all request inputs are ignored
// at any other time. A request with an out-of-range select is consumed
// but not started and pulses err in the following cycle.
//
// Actuator outputs, busy and done are registered and are a pure decode of
// the state being entered, so they line up exactly with the state register.
// dbg_state exposes the current FSM state for checkers.
module aquaflex_route_seq #(
   parameter int N_IN      = 5,
   parameter int N_OUT     = 3,
   parameter int TW        = 16,
   parameter int LOAD_CYC  = 4,
   parameter int DRAIN_CYC = 6,
   parameter int FLUSH_CYC = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [$clog2(N_IN)-1:0]  req_in_sel,
   input  logic [$clog2(N_OUT)-1:0] req_out_sel,
   input  logic [TW-1:0]            req_mix_cyc,
   input  logic                     abort,
   output logic [N_IN-1:0]          in_valve,
   output logic [N_OUT-1:0]         out_valve,
   output logic                     pump_a_en,
   output logic                     mixer_en,
   output logic                     pump_c_en,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [3:0]               dbg_state
);

   localparam int IW = $clog2(N_IN);
   localparam int OW = $clog2(N_OUT);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_LOAD  = 4'd1,
      S_GAP1  = 4'd2,
      S_MIX   = 4'd3,
      S_GAP2  = 4'd4,
      S_DRAIN = 4'd5,
`ifdef AQUAFLEX_FLUSH_EN
      S_GAP0  = 4'd7,
      S_FLUSH = 4'd8,
`endif
      S_DONE  = 4'd6
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [IW-1:0]   in_sel_q, in_sel_d;
   logic [OW-1:0]   out_sel_q, out_sel_d;
   logic [TW-1:0]   mix_q, mix_d;
   logic            err_d;
   logic            accept;
   logic            sel_bad;
   logic            timer_zero;

   logic [N_IN-1:0]  in_valve_d;
   logic [N_OUT-1:0] out_valve_d;
   logic             pump_a_d, mixer_d, pump_c_d, busy_d, done_d;

   // An abort in the DONE cycle wins over a new request.
   assign req_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && !abort);
   assign accept     = req_valid && req_ready;
   assign sel_bad    = (int'(req_in_sel) >= N_IN) || (int'(req_out_sel) >= N_OUT);
   assign timer_zero = (timer_q == '0);
   assign dbg_state  = state_q;

   // Next-state, timer and capture logic, followed by actuator decode of the next state.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      in_sel_d    = in_sel_q;
      out_sel_d   = out_sel_q;
      mix_d       = mix_q;
      err_d       = 1'b0;
      in_valve_d  = '0;
      out_valve_d = '0;
      pump_a_d    = 1'b0;
      mixer_d     = 1'b0;
      pump_c_d    = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               if (sel_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d   = S_LOAD;
                  timer_d   = TW'(LOAD_CYC - 1);
                  in_sel_d  = req_in_sel;
                  out_sel_d = req_out_sel;
                  mix_d     = req_mix_cyc;
               end
            end
         end
         S_LOAD: begin
            if (timer_zero) state_d = S_GAP1;
            else            timer_d = timer_q - TW'(1);
         end
         S_GAP1: begin
            // A zero-length mix skips MIX and its trailing gap entirely.
            if (mix_q == '0) begin
               state_d = S_DRAIN;
               timer_d = TW'(DRAIN_CYC - 1);
            end else begin
               state_d = S_MIX;
               timer_d = mix_q - TW'(1);
            end
         end
         S_MIX: begin
            if (timer_zero) state_d = S_GAP2;
            else            timer_d = timer_q - TW'(1);
         end
         S_GAP2: begin
            state_d = S_DRAIN;
            timer_d = TW'(DRAIN_CYC - 1);
         end
         S_DRAIN: begin
            if (timer_zero) begin
`ifdef AQUAFLEX_FLUSH_EN
               state_d = S_GAP0;
`else
               state_d = S_DONE;
`endif
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
`ifdef AQUAFLEX_FLUSH_EN
         S_GAP0: begin
            state_d = S_FLUSH;
            timer_d = TW'(FLUSH_CYC - 1);
         end
         S_FLUSH: begin
            if (timer_zero) state_d = S_DONE;
            else            timer_d = timer_q - TW'(1);
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Abort takes effect on the next edge from any active state.
      if (abort && (state_q != S_IDLE)) state_d = S_IDLE;

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      case (state_d)
         S_LOAD: begin
            in_valve_d = N_IN'(1) << in_sel_d;
            pump_a_d   = 1'b1;
         end
         S_MIX: mixer_d = 1'b1;
         S_DRAIN: begin
            out_valve_d = N_OUT'(1) << out_sel_d;
            pump_c_d    = 1'b1;
         end
`ifdef AQUAFLEX_FLUSH_EN
         S_FLUSH: begin
            // Buffer inlet through to the outlet: the only phase with both pumps on.
            in_valve_d  = N_IN'(1);
            out_valve_d = N_OUT'(1) << out_sel_d;
            pump_a_d    = 1'b1;
            pump_c_d    = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // State, timer, captured request and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         in_sel_q  <= '0;
         out_sel_q <= '0;
         mix_q     <= '0;
         err       <= 1'b0;
         in_valve  <= '0;
         out_valve <= '0;
         pump_a_en <= 1'b0;
         mixer_en  <= 1'b0;
         pump_c_en <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         in_sel_q  <= in_sel_d;
         out_sel_q <= out_sel_d;
         mix_q     <= mix_d;
         err       <= err_d;
         in_valve  <= in_valve_d;
         out_valve <= out_valve_d;
         pump_a_en <= pump_a_d;
         mixer_en  <= mixer_d;
         pump_c_en <= pump_c_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_aquaflex_route_seq.sv
// tb_aquaflex_route_seq: directed bench for aquaflex_route_seq at default
// parameters. Cycle 0 is the cycle in which a request is presented; the
// DUT is sampled on the falling edge of every following cycle.
// Observed vector layout (15 bits):
//   {in_valve[4:0], out_valve[2:0], pump_a_en, mixer_en, pump_c_en,
//    busy, done, req_ready, err}
module tb_aquaflex_route_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_in_sel;
   logic [1:0]  req_out_sel;
   logic [15:0] req_mix_cyc;
   logic        abort;
   logic [4:0]  in_valve;
   logic [2:0]  out_valve;
   logic        pump_a_en, mixer_en, pump_c_en;
   logic        busy, done, err;
   logic [3:0]  dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [14:0] IDLE_VEC = 15'b000000000000010;
   localparam logic [14:0] ERR_VEC  = 15'b000000000000011;

   // Clock and reset.
   always #5 clk = ~clk;

   aquaflex_route_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_in_sel  (req_in_sel),
      .req_out_sel (req_out_sel),
      .req_mix_cyc (req_mix_cyc),
      .abort       (abort),
      .in_valve    (in_valve),
      .out_valve   (out_valve),
      .pump_a_en   (pump_a_en),
      .mixer_en    (mixer_en),
      .pump_c_en   (pump_c_en),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .dbg_state   (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [14:0] obs_vec();
      return {in_valve, out_valve, pump_a_en, mixer_en, pump_c_en, busy, done, req_ready, err};
   endfunction

   // Expected outputs in cycle c of a transfer whose phase windows were worked out by hand:
   // LOAD 1-4, gap 5, MIX 6..5+mix, DRAIN drain_lo..drain_lo+5, (GAP0, FLUSH x8), DONE done_cyc.
   function automatic logic [14:0] exp_vec(int c, int isel, int osel, int mix, int drain_lo, int done_cyc);
      logic [4:0] iv;
      logic [2:0] ov;
      logic pa, mx, pc, bz, dn, rd;
      iv = '0; ov = '0; pa = 0; mx = 0; pc = 0;
      if (c >= 1 && c <= 4) begin iv = 5'd1 << isel; pa = 1; end
      if (mix > 0 && c >= 6 && c <= 5 + mix) mx = 1;
      if (c >= drain_lo && c <= drain_lo + 5) begin ov = 3'd1 << osel; pc = 1; end
`ifdef AQUAFLEX_FLUSH_EN
      if (c >= drain_lo + 7 && c <= drain_lo + 14) begin iv = 5'd1; ov = 3'd1 << osel; pa = 1; pc = 1; end
`endif
      bz = (c >= 1 && c <= done_cyc);
      dn = (c == done_cyc);
      rd = (c >= done_cyc);
      return {iv, ov, pa, mx, pc, bz, dn, rd, 1'b0};
   endfunction

   // Present one request and follow it cycle by cycle; abort_cyc > 0 raises abort in that cycle.
   task automatic run_trace(input string tag, input int isel, input int osel, input int mix,
                            input int drain_lo, input int done_cyc, input int abort_cyc);
      logic [14:0] exp;
      @(negedge clk);
      req_valid   = 1'b1;
      req_in_sel  = isel[2:0];
      req_out_sel = osel[1:0];
      req_mix_cyc = mix[15:0];
      check($sformatf("%s_c0_ready", tag), {31'd0, req_ready}, 32'd1);
      for (int c = 1; c <= done_cyc + 1; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
         abort = 1'b0;
         if (abort_cyc > 0 && c > abort_cyc) exp = IDLE_VEC;
         else exp = exp_vec(c, isel, osel, mix, drain_lo, done_cyc);
         check($sformatf("%s_c%0d", tag, c), {17'd0, obs_vec()}, {17'd0, exp});
         if (c == abort_cyc) abort = 1'b1;
      end
   endtask

   // Rejected request: err pulses once, nothing else moves.
   task automatic run_bad(input string tag, input int isel, input int osel);
      @(negedge clk);
      req_valid   = 1'b1;
      req_in_sel  = isel[2:0];
      req_out_sel = osel[1:0];
      req_mix_cyc = 16'd3;
      @(negedge clk);
      req_valid = 1'b0;
      check($sformatf("%s_c1", tag), {17'd0, obs_vec()}, {17'd0, ERR_VEC});
      @(negedge clk);
      check($sformatf("%s_c2", tag), {17'd0, obs_vec()}, {17'd0, IDLE_VEC});
   endtask

   // Second request held valid into the DONE cycle of the first and accepted there.
   task automatic run_b2b(input int done_cyc);
      @(negedge clk);
      req_valid = 1'b1; req_in_sel = 3'd0; req_out_sel = 2'd2; req_mix_cyc = 16'd0;
      for (int c = 1; c <= done_cyc; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
         check($sformatf("b2b_a_c%0d", c), {17'd0, obs_vec()}, {17'd0, exp_vec(c, 0, 2, 0, 6, done_cyc)});
         if (c == done_cyc - 1) begin
            req_valid = 1'b1; req_in_sel = 3'd4; req_out_sel = 2'd2; req_mix_cyc = 16'd0;
         end
      end
      for (int c = 1; c <= done_cyc + 1; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
         check($sformatf("b2b_b_c%0d", c), {17'd0, obs_vec()}, {17'd0, exp_vec(c, 4, 2, 0, 6, done_cyc)});
      end
   endtask

   // Reset asserted in the middle of MIX.
   task automatic run_reset_mid_mix();
      @(negedge clk);
      req_valid = 1'b1; req_in_sel = 3'd1; req_out_sel = 2'd0; req_mix_cyc = 16'd10;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
         check($sformatf("rst_mix_c%0d", c), {17'd0, obs_vec()}, {17'd0, exp_vec(c, 1, 0, 10, 17, 23)});
      end
      #2 rst_n = 1'b0;
      #1 check("rst_async_outputs", {17'd0, obs_vec()}, {17'd0, IDLE_VEC});
      check("rst_async_state", {28'd0, dbg_state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_release_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      check("rst_after_release", {17'd0, obs_vec()}, {17'd0, IDLE_VEC});
   endtask

   initial begin
      int done_nom, done_zero, done_one;
`ifdef AQUAFLEX_FLUSH_EN
      done_nom = 32; done_zero = 21; done_one = 23;
`else
      done_nom = 23; done_zero = 12; done_one = 14;
`endif
      rst_n = 1'b0; req_valid = 1'b0; req_in_sel = '0; req_out_sel = '0;
      req_mix_cyc = '0; abort = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {17'd0, obs_vec()}, {17'd0, IDLE_VEC});
      check("reset_state", {28'd0, dbg_state}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset", {17'd0, obs_vec()}, {17'd0, IDLE_VEC});

      // Nominal, zero-mix and single-cycle mix transfers.
      run_trace("nominal", 2, 1, 10, 17, done_nom, 0);
      run_trace("zero_mix", 3, 2, 0, 6, done_zero, 0);
      run_trace("mix_one", 0, 0, 1, 8, done_one, 0);

      // Out-of-range selects.
      run_bad("bad_in", 6, 0);
      run_bad("bad_out", 1, 3);

      // Abort in MIX and in the last DRAIN cycle.
      run_trace("abort_mix", 2, 1, 10, 17, done_nom, 8);
      run_trace("abort_last_drain", 3, 0, 0, 6, done_zero, 11);

      // Abort while idle changes nothing.
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      check("abort_idle_a", {17'd0, obs_vec()}, {17'd0, IDLE_VEC});
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle_b", {17'd0, obs_vec()}, {17'd0, IDLE_VEC});

      run_b2b(done_zero);
      run_reset_mid_mix();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
